// File: rtl/reg_file_wb_port.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_wb_port
// Brief    : General-purpose register file fed by the write-back stage.
//            Two combinational read ports with optional same-cycle write
//            bypass. After reset a sequencer zeroes one entry per cycle and
//            init_done stays low until the whole array has been cleared.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_wb_port #(
    parameter int word_size = 32,
    parameter int reg_size  = 5,
    parameter bit BYPASS    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RegWrite,
    input  logic [reg_size-1:0]  WriteReg,
    input  logic [word_size-1:0] WriteData,
    input  logic [reg_size-1:0]  ReadReg1,
    input  logic [reg_size-1:0]  ReadReg2,
    output logic [word_size-1:0] ReadData1,
    output logic [word_size-1:0] ReadData2,
    output logic                 init_done
);

    localparam int DEPTH = 2 ** reg_size;

    // One extra pointer bit keeps the terminal count distinct from entry 0.
    localparam logic [reg_size:0] c_LAST_PTR = (reg_size + 1)'(DEPTH - 1);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [reg_size:0]     r_clr_ptr;
    logic [reg_size:0]     w_clr_ptr_next;
    logic                  r_init_done;
    logic                  w_init_done_next;
    logic [word_size-1:0]  r_mem [DEPTH];

    // Read mux shared by both ports: gated by init_done, r0 hard-wired to
    // zero, optional forwarding of the write-back value on address match.
    function automatic logic [word_size-1:0] read_sel(
        input logic                 ready,
        input logic [reg_size-1:0]  raddr,
        input logic [word_size-1:0] arr_val,
        input logic                 we,
        input logic [reg_size-1:0]  waddr,
        input logic [word_size-1:0] wdata
    );
        logic [word_size-1:0] val;
        val = '0;
        if (ready && (raddr != '0)) begin
            if (BYPASS && we && (waddr == raddr)) begin
                val = wdata;
            end else begin
                val = arr_val;
            end
        end
        return val;
    endfunction

    // Sequencer state register; reset restarts the clear from entry 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= CLEAR;
            r_clr_ptr   <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_clr_ptr   <= w_clr_ptr_next;
            r_init_done <= w_init_done_next;
        end
    end

    // Next-state logic: walk the pointer through the array, then park in READY.
    always_comb begin
        w_state_next     = r_state;
        w_clr_ptr_next   = r_clr_ptr;
        w_init_done_next = r_init_done;
        case (r_state)
            CLEAR: begin
                w_clr_ptr_next = r_clr_ptr + 1'b1;
                if (r_clr_ptr == c_LAST_PTR) begin
                    w_state_next     = READY;
                    w_init_done_next = 1'b1;
                end
            end
            READY: begin
                w_init_done_next = 1'b1;
            end
            default: begin
                w_state_next     = CLEAR;
                w_clr_ptr_next   = '0;
                w_init_done_next = 1'b0;
            end
        endcase
    end

    // Array update: clear writes while sequencing, WB writes once ready.
    // The reset edge itself leaves the contents alone.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (r_state == CLEAR) begin
                r_mem[r_clr_ptr[reg_size-1:0]] <= '0;
            end else if (RegWrite && (WriteReg != '0)) begin
                r_mem[WriteReg] <= WriteData;
            end
        end
    end

    // Read port 1 (rs).
    always_comb begin
        ReadData1 = read_sel(r_init_done, ReadReg1, r_mem[ReadReg1],
                             RegWrite, WriteReg, WriteData);
    end

    // Read port 2 (rt).
    always_comb begin
        ReadData2 = read_sel(r_init_done, ReadReg2, r_mem[ReadReg2],
                             RegWrite, WriteReg, WriteData);
    end

    assign init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wb_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_wb_port
// Brief    : Self-checking bench for reg_file_wb_port. Drives one bypassing
//            and one non-bypassing instance from shared stimulus; a reference
//            model predicts read data and init_done, a monitor compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_wb_port;

    logic        clk;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        done_b, done_n;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    reg_file_wb_port #(.word_size(32), .reg_size(5), .BYPASS(1'b1)) dut_byp (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(rd1_b), .ReadData2(rd2_b), .init_done(done_b)
    );

    reg_file_wb_port #(.word_size(32), .reg_size(5), .BYPASS(1'b0)) dut_nob (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(rd1_n), .ReadData2(rd2_n), .init_done(done_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: count good edges since reset; after 32 the array is
    // all zero (nothing else can land during the clear), then WB writes apply.
    logic [31:0] ref_mem [32];
    int          ref_edges = 0;

    typedef struct {
        int          cyc;
        logic [31:0] r1b, r2b, r1n, r2n;
        logic        done;
    } exp_t;
    exp_t sb[$];

    function automatic logic [31:0] ref_read(input bit byp, input logic [4:0] a);
        if (ref_edges < 32) return 32'h0;
        if (a == 5'd0) return 32'h0;
        if (byp && RegWrite && (WriteReg == a)) return WriteData;
        return ref_mem[a];
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            ref_edges = 0;
        end else if (ref_edges < 32) begin
            ref_edges++;
            if (ref_edges == 32) begin
                for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
            end
        end else if (RegWrite && (WriteReg != 5'd0)) begin
            ref_mem[WriteReg] = WriteData;
        end
    endtask

    // One cycle of stimulus: retire the edge into the model, apply new
    // inputs, push the predicted outputs for this cycle.
    task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        rst_n     = rst;
        RegWrite  = we;
        WriteReg  = wa;
        WriteData = wd;
        ReadReg1  = a1;
        ReadReg2  = a2;
        cyc++;
        e.cyc  = cyc;
        e.r1b  = ref_read(1'b1, a1);
        e.r2b  = ref_read(1'b1, a2);
        e.r1n  = ref_read(1'b0, a1);
        e.r2n  = ref_read(1'b0, a2);
        e.done = (ref_edges >= 32);
        sb.push_back(e);
    endtask

    task automatic rand_step(input logic rst);
        logic [4:0]  wa;
        logic [4:0]  a1;
        logic [4:0]  a2;
        wa = 5'($urandom);
        a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
        a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
        step(rst, 1'($urandom), wa, $urandom, a1, a2);
    endtask

    task automatic check(input string name, input int c, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %h expected %h", name, c, act, exp);
        end
    endtask

    // Monitor: compare the DUT outputs against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("rd1_bypass",    e.cyc, rd1_b, e.r1b);
                check("rd2_bypass",    e.cyc, rd2_b, e.r2b);
                check("rd1_nobypass",  e.cyc, rd1_n, e.r1n);
                check("rd2_nobypass",  e.cyc, rd2_n, e.r2n);
                check("init_done_byp", e.cyc, 32'(done_b), 32'(e.done));
                check("init_done_nob", e.cyc, 32'(done_n), 32'(e.done));
            end
        end
    end

    initial begin
        rst_n = 1'b0; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
        ReadReg1 = '0; ReadReg2 = '0;

        // Reset, then the full clear with reads and stray writes in flight.
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int i = 0; i < 34; i++) begin
            if (i == 5) step(1'b1, 1'b1, 5'd3, 32'hFFFF_FFFF, 5'd3, 5'd3);
            else        rand_step(1'b1);
        end
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd7);

        // Directed: write then read, r0 drop, same-cycle bypass.
        step(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
        step(1'b1, 1'b1, 5'd0, 32'h0000_1234, 5'd0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        step(1'b1, 1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd7);
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd3);
        step(1'b1, 1'b1, 5'd31, 32'h1357_9BDF, 5'd31, 5'd1);
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd31, 5'd31);

        for (int i = 0; i < 150; i++) rand_step(1'b1);

        // Reset during operation, then again at clear pointer 10.
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
        for (int i = 0; i < 10; i++) rand_step(1'b1);
        step(1'b0, 1'b1, 5'd9, 32'h0BAD_F00D, 5'd9, 5'd5);
        for (int i = 0; i < 36; i++) rand_step(1'b1);

        for (int i = 0; i < 100; i++) rand_step(1'b1);
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual %0d expected 0 entries left", sb.size());
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
